// File: rtl/image_write.sv
// Streams pixel-group beats into image memory as a (w, h, d) raster walk starting
// at a configurable base. Addresses come from running row/depth base pointers.
module image_write #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int GROUP_NB   = 4,
  parameter int IMG_WIDTH  = 16,
  parameter int MEM_AWIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CFG_DWIDTH-1:0]           cfg_data,
  input  logic [CFG_AWIDTH-1:0]           cfg_addr,
  input  logic                            cfg_valid,
  input  logic                            next,
  input  logic [GROUP_NB*IMG_WIDTH-1:0]   result_bus,
  input  logic                            result_last,
  input  logic                            result_val,
  output logic                            result_rdy,
  output logic                            wr_val,
  output logic [MEM_AWIDTH-1:0]           wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0]   wr_data,
  output logic                            done,
  output logic                            err
);

  localparam int CFG_IW_START  = 8;
  localparam int CFG_IW_IMG_W  = 9;
  localparam int CFG_IW_IMG_DH = 10;
  localparam int CFG_IW_STRIDE = 11;

  localparam int RESET  = 0;
  localparam int ACTIVE = 1;
  localparam int DONE   = 2;

  localparam int BUS_W = GROUP_NB * IMG_WIDTH;

  typedef enum logic [2:0] {
    S_RESET  = 3'b001,
    S_ACTIVE = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MEM_AWIDTH-1:0] cfg_start;
  logic [15:0]           img_w;
  logic [15:0]           img_h;
  logic [15:0]           img_d;
  logic [15:0]           row_stride;
  logic [15:0]           depth_stride;

  logic [15:0]           w;
  logic [15:0]           h;
  logic [15:0]           d;
  logic [MEM_AWIDTH-1:0] row_base;
  logic [MEM_AWIDTH-1:0] depth_base;

  logic                  vld_p1;
  logic [MEM_AWIDTH-1:0] addr_p1;
  logic [BUS_W-1:0]      data_p1;

  logic accept;
  logic w_end;
  logic h_end;
  logic d_end;
  logic final_beat;
  logic [MEM_AWIDTH-1:0] next_depth_base;

  assign result_rdy      = state[ACTIVE];
  assign done            = state[DONE];
  assign accept          = result_val & state[ACTIVE];
  assign w_end           = (w == img_w);
  assign h_end           = (h == img_h);
  assign d_end           = (d == img_d);
  assign final_beat      = w_end & h_end & d_end;
  assign next_depth_base = depth_base + MEM_AWIDTH'(depth_stride);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  if (next) state_nxt = S_ACTIVE;
      S_ACTIVE: if (accept && final_beat) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_RESET;
      default:  state_nxt = S_RESET;
    endcase
  end

  // Config registers, raster counters and base pointers; config only writable while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_start    <= '0;
      img_w        <= '0;
      img_h        <= '0;
      img_d        <= '0;
      row_stride   <= '0;
      depth_stride <= '0;
      w            <= '0;
      h            <= '0;
      d            <= '0;
      row_base     <= '0;
      depth_base   <= '0;
      err          <= 1'b0;
    end else if (state[RESET]) begin
      if (cfg_valid) begin
        case (cfg_addr)
          CFG_AWIDTH'(CFG_IW_START):  cfg_start <= cfg_data[MEM_AWIDTH-1:0];
          CFG_AWIDTH'(CFG_IW_IMG_W):  img_w     <= cfg_data[15:0];
          CFG_AWIDTH'(CFG_IW_IMG_DH): begin
            img_d <= cfg_data[31:16];
            img_h <= cfg_data[15:0];
          end
          CFG_AWIDTH'(CFG_IW_STRIDE): begin
            depth_stride <= cfg_data[31:16];
            row_stride   <= cfg_data[15:0];
          end
          default: ;
        endcase
      end
      if (next) begin
        w          <= '0;
        h          <= '0;
        d          <= '0;
        row_base   <= cfg_start;
        depth_base <= cfg_start;
        err        <= 1'b0;
      end
    end else if (accept) begin
      if (result_last != final_beat) err <= 1'b1;
      if (!w_end) begin
        w <= w + 16'd1;
      end else begin
        w <= '0;
        if (!h_end) begin
          h        <= h + 16'd1;
          row_base <= row_base + MEM_AWIDTH'(row_stride);
        end else begin
          // New depth plane: rows restart from the advanced depth pointer.
          h          <= '0;
          d          <= d + 16'd1;
          depth_base <= next_depth_base;
          row_base   <= next_depth_base;
        end
      end
    end
  end

  // Stage p1: registered memory write, one cycle after beat acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= row_base + MEM_AWIDTH'(w);
        data_p1 <= result_bus;
      end
    end
  end

  assign wr_val  = vld_p1;
  assign wr_addr = addr_p1;
  assign wr_data = data_p1;

endmodule

// File: tb/tb_image_write.sv
// Randomized bench for image_write: a frame-level reference model (address list built
// from nested raster loops) is compared against the DUT outputs every cycle.
module tb_image_write;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;
  logic        cfg_valid;
  logic        next;
  logic [63:0] result_bus;
  logic        result_last;
  logic        result_val;
  logic        result_rdy;
  logic        wr_val;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  image_write dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .next(next), .result_bus(result_bus), .result_last(result_last), .result_val(result_val),
    .result_rdy(result_rdy), .wr_val(wr_val), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 streaming, 2 done pulse.
  int          m_phase = 0;
  logic        m_wval = 1'b0;
  logic [15:0] m_waddr = '0;
  logic [63:0] m_wdata = '0;
  logic        m_err = 1'b0;
  int          m_idx = 0;
  int          m_total = 0;
  logic [31:0] m_cfg [4];
  logic [15:0] m_q[$];

  task automatic build_list();
    int st, ww, hh, dd, rs, ds, a;
    st = int'(m_cfg[0][15:0]);
    ww = int'(m_cfg[1][15:0]);
    hh = int'(m_cfg[2][15:0]);
    dd = int'(m_cfg[2][31:16]);
    rs = int'(m_cfg[3][15:0]);
    ds = int'(m_cfg[3][31:16]);
    m_q.delete();
    for (int z = 0; z <= dd; z++)
      for (int y = 0; y <= hh; y++)
        for (int x = 0; x <= ww; x++) begin
          a = st + z * ds + y * rs + x;
          m_q.push_back(16'(a));
        end
    m_total = m_q.size();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_cfg[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_phase = 0; m_wval = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
        m_idx = 0; m_total = 0;
        for (int i = 0; i < 4; i++) m_cfg[i] = '0;
      end else begin
        m_wval = 1'b0;
        case (m_phase)
          0: begin
            if (next) begin
              build_list();
              m_phase = 1; m_idx = 0; m_err = 1'b0;
            end
            if (cfg_valid && cfg_addr >= 5'd8 && cfg_addr <= 5'd11)
              m_cfg[int'(cfg_addr) - 8] = cfg_data;
          end
          1: begin
            if (result_val) begin
              m_wval  = 1'b1;
              m_wdata = result_bus;
              m_waddr = m_q[m_idx];
              if (result_last != (m_idx == m_total - 1)) m_err = 1'b1;
              if (m_idx == m_total - 1) m_phase = 2;
              m_idx++;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle compare and write log.
  logic        chk_on = 1'b0;
  int          cyc = 0;
  logic [15:0] log_addr[$];
  int          log_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on) begin
        chk("result_rdy", 64'(result_rdy), 64'(m_phase == 1));
        chk("wr_val",     64'(wr_val),     64'(m_wval));
        chk("wr_addr",    64'(wr_addr),    64'(m_waddr));
        chk("wr_data",    wr_data,         m_wdata);
        chk("done",       64'(done),       64'(m_phase == 2));
        chk("err",        64'(err),        64'(m_err));
        if (wr_val) begin
          log_addr.push_back(wr_addr);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] dat);
    @(negedge clk); cfg_valid = 1'b1; cfg_addr = a; cfg_data = dat;
    @(negedge clk); cfg_valid = 1'b0;
  endtask

  task automatic setup(input logic [15:0] st, input logic [15:0] w, input logic [15:0] h,
                       input logic [15:0] dd, input logic [15:0] rs, input logic [15:0] ds);
    cfg_write(5'd8,  {16'h0, st});
    cfg_write(5'd9,  {16'h0, w});
    cfg_write(5'd10, {dd, h});
    cfg_write(5'd11, {ds, rs});
  endtask

  task automatic start_frame();
    log_addr.delete();
    log_cyc.delete();
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
  endtask

  // mode 0: valid held, 1: toggling, 2: random. bad_last>0 marks that beat as last instead.
  task automatic run_frame(input int mode, input int bad_last, input int inject, input int stop_at);
    int cnt;
    cnt = 0;
    while (m_phase != 0 && cnt < 5000) begin
      if (stop_at > 0 && m_idx == stop_at) break;
      case (mode)
        0:       result_val = 1'b1;
        1:       result_val = (cnt % 2 == 0);
        default: result_val = ($urandom_range(0, 3) != 0);
      endcase
      result_bus  = {$urandom, $urandom};
      result_last = (bad_last > 0) ? (m_idx + 1 == bad_last) : (m_idx + 1 == m_total);
      if (inject > 0 && m_idx == inject) begin
        cfg_valid = 1'b1; cfg_addr = 5'd8; cfg_data = 32'h5555; next = 1'b1;
      end else begin
        cfg_valid = 1'b0; next = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    result_val = 1'b0; result_last = 1'b0; cfg_valid = 1'b0; next = 1'b0;
    if (cnt >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got %0d cycles, required frame end", cnt);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0; next = 1'b0;
    result_bus = '0; result_last = 1'b0; result_val = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_rdy",  64'(result_rdy), 64'(0));
    chk("rst_wval", 64'(wr_val),     64'(0));
    chk("rst_done", 64'(done),       64'(0));
    chk("rst_err",  64'(err),        64'(0));
    chk("rst_addr", 64'(wr_addr),    64'(0));
    chk("rst_data", wr_data,         64'(0));

    // Single-beat frame with all-zero config.
    start_frame();
    run_frame(0, 0, 0, 0);
    chk("one_beat_cnt",  64'(log_addr.size()), 64'(1));
    chk("one_beat_addr", 64'(log_addr[0]),     64'(0));

    // Reference frame, valid held high.
    setup(16'h0100, 16'd9, 16'd4, 16'd1, 16'd16, 16'd128);
    start_frame();
    chk("model_b1",   64'(m_q[0]),  64'h0100);
    chk("model_b11",  64'(m_q[10]), 64'h0110);
    chk("model_b51",  64'(m_q[50]), 64'h0180);
    chk("model_b100", 64'(m_q[99]), 64'h01C9);
    run_frame(0, 0, 0, 0);
    chk("ref_cnt",  64'(log_addr.size()), 64'(100));
    chk("ref_b1",   64'(log_addr[0]),  64'h0100);
    chk("ref_b11",  64'(log_addr[10]), 64'h0110);
    chk("ref_b51",  64'(log_addr[50]), 64'h0180);
    chk("ref_b100", 64'(log_addr[99]), 64'h01C9);
    chk("ref_span", 64'(log_cyc[99] - log_cyc[0] + 1), 64'(100));
    chk("ref_err",  64'(err), 64'(0));

    // Toggling valid.
    start_frame();
    run_frame(1, 0, 0, 0);
    chk("tog_cnt",  64'(log_addr.size()), 64'(100));
    chk("tog_b100", 64'(log_addr[99]),    64'h01C9);
    chk("tog_span", 64'(log_cyc[99] - log_cyc[0] + 1), 64'(199));

    // Early last marker on beat 50.
    start_frame();
    run_frame(0, 50, 0, 0);
    chk("early_cnt",  64'(log_addr.size()), 64'(100));
    chk("err_sticky", 64'(err), 64'(1));
    start_frame();
    chk("err_cleared", 64'(err), 64'(0));
    run_frame(0, 0, 0, 0);

    // Config write and next during ACTIVE are ignored.
    start_frame();
    run_frame(0, 0, 20, 0);
    chk("inj_cnt", 64'(log_addr.size()), 64'(100));
    start_frame();
    run_frame(0, 0, 0, 0);
    chk("inj_start", 64'(log_addr[0]), 64'h0100);

    // Address wrap at the top of memory.
    setup(16'hFFFE, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    start_frame();
    run_frame(0, 0, 0, 0);
    chk("wrap_cnt", 64'(log_addr.size()), 64'(4));
    chk("wrap_a0",  64'(log_addr[0]), 64'hFFFE);
    chk("wrap_a1",  64'(log_addr[1]), 64'hFFFF);
    chk("wrap_a2",  64'(log_addr[2]), 64'h0000);
    chk("wrap_a3",  64'(log_addr[3]), 64'h0001);

    // Reset mid-frame after beat 37, then a fresh frame at a new start.
    setup(16'h0100, 16'd9, 16'd4, 16'd1, 16'd16, 16'd128);
    start_frame();
    run_frame(0, 0, 0, 37);
    rst = 1'b1; result_val = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    result_val = 1'b0;
    chk("rst_mid_cnt", 64'(log_addr.size()), 64'(37));
    chk("rst_mid_rdy", 64'(result_rdy), 64'(0));
    setup(16'h0200, 16'd9, 16'd4, 16'd1, 16'd16, 16'd128);
    start_frame();
    run_frame(0, 0, 0, 0);
    chk("restart_a0",  64'(log_addr[0]), 64'h0200);
    chk("restart_cnt", 64'(log_addr.size()), 64'(100));
    chk("restart_err", 64'(err), 64'(0));

    // Randomized frames with stray config writes and occasional wrong last markers.
    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 3)) cfg_write(5'($urandom_range(0, 31)), $urandom);
      setup(16'($urandom), 16'($urandom_range(0, 6)), 16'($urandom_range(0, 3)),
            16'($urandom_range(0, 2)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) cfg_write(5'($urandom_range(12, 31)), $urandom);
      start_frame();
      run_frame(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_write.md
IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CFG_DWIDTH, 32, config data width
- CFG_AWIDTH, 5, config address width
- GROUP_NB, 4, pixels per beat
- IMG_WIDTH, 16, bits per pixel
- MEM_AWIDTH, 16, image memory address width
REQ-002 Config register addresses SHALL be localparams:
- CFG_IW_START = 8, base address
- CFG_IW_IMG_W = 9, width-1 in [15:0]
- CFG_IW_IMG_DH = 10, {depth-1 [31:16], height-1 [15:0]}
- CFG_IW_STRIDE = 11, {depth_stride [31:16], row_stride [15:0]}
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset
- cfg_data, in, CFG_DWIDTH, config data
- cfg_addr, in, CFG_AWIDTH, config register select
- cfg_valid, in, 1, config write strobe
- next, in, 1, start one frame
- result_bus, in, GROUP_NB*IMG_WIDTH, pixel group
- result_last, in, 1, producer's final-beat marker
- result_val, in, 1, beat valid
- result_rdy, out, 1, beat accepted when high with result_val
- wr_val, out, 1, memory write enable
- wr_addr, out, MEM_AWIDTH, memory write address
- wr_data, out, GROUP_NB*IMG_WIDTH, memory write data
- done, out, 1, one-cycle frame-complete pulse
- err, out, 1, sticky last-marker mismatch flag
REQ-004 One clock, clk; reset rst is synchronous and active-high.

Function
REQ-005 One-hot state register `state`, index localparams RESET=0, ACTIVE=1, DONE=2.
REQ-006 In RESET: a cfg_valid write to a listed address SHALL update that register on the next clk edge; unlisted addresses are ignored.
REQ-007 In ACTIVE or DONE, cfg_valid writes are ignored.
REQ-008 next in RESET SHALL:
- go to ACTIVE
- clear counters w, h, d to 0
- load row and depth base pointers from CFG_IW_START
- clear err
REQ-009 next outside RESET is ignored.
REQ-010 result_rdy = state[ACTIVE], combinational from state only.
REQ-011 Beat accepted (result_val & result_rdy) on cycle N SHALL, at cycle N+1:
- wr_val=1
- wr_data = that beat's result_bus
- wr_addr = START + d*depth_stride + h*row_stride + w, computed incrementally (row/depth base pointers plus w), no multipliers
REQ-012 wr_val = 0 in every cycle not following an accepted beat; wr_addr/wr_data hold their last values.
REQ-013 Counter order: w fastest, then h, then d.
- w wraps at IMG_W to 0 and increments h.
- h wraps at IMG_H to 0 and increments d.
- Address arithmetic SHALL be MEM_AWIDTH bits, modulo 2^MEM_AWIDTH.
REQ-014 Accepted beat with w==IMG_W, h==IMG_H, d==IMG_D is the final beat:
- state SHALL go ACTIVE->DONE on the same edge
- result_rdy SHALL drop the next cycle
REQ-015 In DONE: done=1 for exactly one cycle, then state returns to RESET.
- done coincides with the final beat's wr_val.
REQ-016 err SHALL set (sticky) when result_last differs from the final-beat condition on any accepted beat; it has no effect on flow.
REQ-017 result_val without result_rdy SHALL cause no write and no counter change.
REQ-018 Frame of one beat (all cfg fields 0) SHALL go RESET->ACTIVE->DONE->RESET with exactly one write at START.

Reset
REQ-019 rst SHALL have priority over all inputs at any state, including mid-frame. After rst:
- state=RESET
- result_rdy=0, wr_val=0, done=0, err=0
- wr_addr=0, wr_data=0
- counters=0
- all config registers=0
- no further writes until the next `next`

Verification
REQ-020 Config START=0x0100, W=9, DH={1,4}, STRIDE={128,16}, next, result_val held 1:
- 100 writes on consecutive cycles
- beat 1 at 0x0100, beat 11 at 0x0110, beat 51 at 0x0180, beat 100 at 0x01C9
- done coincides with the 100th wr_val; err=0 with result_last on beat 100 only
REQ-021 Same config, result_val toggling 1/0 each cycle:
- identical address/data sequence
- wr_val only on cycles following accepted beats
- frame completes in 199 cycles
REQ-022 rst asserted after beat 37, then reconfigure and next:
- no write after reset
- new frame restarts at the new START; err=0
REQ-023 result_last asserted on beat 50:
- err rises one cycle after that acceptance and stays 1
- frame still ends at beat 100; err clears on the following next
REQ-024 cfg_valid writes in ACTIVE, next in ACTIVE, and START=0xFFFE with W=3:
- first two have no effect
- third wraps the address sequence to 0xFFFE, 0xFFFF, 0x0000, 0x0001
